// File: rtl/jelly_fixed_reciprocal_scale.sv
// Signed fixed-point multiply by a precomputed reciprocal, with round-half-up and saturation.
// Three-stage pipeline (operands / full product / rounded result) under a single shared enable.
module jelly_fixed_reciprocal_scale #(
    parameter int unsigned USER_WIDTH       = 0,
    parameter int unsigned NUM_INT_WIDTH    = 16,
    parameter int unsigned NUM_FRAC_WIDTH   = 16,
    parameter int unsigned RECIP_INT_WIDTH  = 16,
    parameter int unsigned RECIP_FRAC_WIDTH = 16,
    parameter int unsigned M_INT_WIDTH      = 16,
    parameter int unsigned M_FRAC_WIDTH     = 16,
    localparam int unsigned USER_BITS = (USER_WIDTH > 0) ? USER_WIDTH : 1,
    localparam int unsigned NUM_W     = NUM_INT_WIDTH + NUM_FRAC_WIDTH,
    localparam int unsigned RECIP_W   = RECIP_INT_WIDTH + RECIP_FRAC_WIDTH,
    localparam int unsigned M_W       = M_INT_WIDTH + M_FRAC_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cke,

    input  logic [USER_BITS-1:0] s_user,
    input  logic [NUM_W-1:0]     s_num,
    input  logic [RECIP_W-1:0]   s_recip,
    input  logic                 s_valid,
    output logic                 s_ready,

    output logic [USER_BITS-1:0] m_user,
    output logic [M_W-1:0]       m_fixed,
    output logic                 m_overflow,
    output logic                 m_valid,
    input  logic                 m_ready
);

    localparam int          SHIFT  = int'(NUM_FRAC_WIDTH + RECIP_FRAC_WIDTH) - int'(M_FRAC_WIDTH);
    localparam int unsigned PROD_W = NUM_W + RECIP_W;
    localparam int unsigned WIDE_W = ((PROD_W > M_W) ? PROD_W : M_W) + 1;

    generate
        if (SHIFT < 0) begin : g_bad_shift
            $error("jelly_fixed_reciprocal_scale: result fraction wider than product fraction");
        end
    endgenerate

    logic w_en;

    logic                 r_s0_valid;
    logic [USER_BITS-1:0] r_s0_user;
    logic [NUM_W-1:0]     r_s0_num;
    logic [RECIP_W-1:0]   r_s0_recip;

    logic                      r_s1_valid;
    logic [USER_BITS-1:0]      r_s1_user;
    logic signed [PROD_W-1:0]  r_s1_prod;

    logic                 r_m_valid;
    logic [USER_BITS-1:0] r_m_user;
    logic [M_W-1:0]       r_m_fixed;
    logic                 r_m_overflow;

    // Output register free (or draining) means every stage may advance.
    assign s_ready = !r_m_valid || m_ready;
    assign w_en    = cke && (!r_m_valid || m_ready);

    // ------------------------------------------------------------------
    // S0: operand capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s0_valid <= 1'b0;
            r_s0_user  <= '0;
            r_s0_num   <= '0;
            r_s0_recip <= '0;
        end else if (w_en) begin
            r_s0_valid <= s_valid;
            r_s0_user  <= s_user;
            r_s0_num   <= s_num;
            r_s0_recip <= s_recip;
        end
    end

    // ------------------------------------------------------------------
    // S1: full-width signed product
    // ------------------------------------------------------------------
    logic signed [PROD_W-1:0] w_num_ext;
    logic signed [PROD_W-1:0] w_recip_ext;
    logic signed [PROD_W-1:0] w_prod;

    assign w_num_ext   = PROD_W'($signed(r_s0_num));
    assign w_recip_ext = PROD_W'($signed(r_s0_recip));
    assign w_prod      = w_num_ext * w_recip_ext;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_user  <= '0;
            r_s1_prod  <= '0;
        end else if (w_en) begin
            r_s1_valid <= r_s0_valid;
            r_s1_user  <= r_s0_user;
            r_s1_prod  <= w_prod;
        end
    end

    // ------------------------------------------------------------------
    // S2: round half toward +inf, then saturate to M_W bits
    // ------------------------------------------------------------------
    logic signed [WIDE_W-1:0] w_ext;
    logic signed [WIDE_W-1:0] w_round;
    logic signed [WIDE_W-1:0] w_sum;
    logic signed [WIDE_W-1:0] w_shifted;
    logic signed [WIDE_W-1:0] w_max;
    logic signed [WIDE_W-1:0] w_min;
    logic [M_W-1:0]           w_res;
    logic                     w_ovf;

    generate
        if (SHIFT > 0) begin : g_round
            assign w_round = WIDE_W'(1) << (SHIFT - 1);
        end else begin : g_no_round
            assign w_round = '0;
        end
    endgenerate

    // Extra headroom bit keeps the rounding add from wrapping.
    assign w_ext     = WIDE_W'(r_s1_prod);
    assign w_sum     = w_ext + w_round;
    assign w_shifted = w_sum >>> SHIFT;
    assign w_max     = (WIDE_W'(1) << (M_W - 1)) - WIDE_W'(1);
    assign w_min     = -(WIDE_W'(1) << (M_W - 1));

    always_comb begin
        w_res = w_shifted[M_W-1:0];
        w_ovf = 1'b0;
        if (w_shifted > w_max) begin
            w_res = {1'b0, {(M_W-1){1'b1}}};
            w_ovf = 1'b1;
        end else if (w_shifted < w_min) begin
            w_res = {1'b1, {(M_W-1){1'b0}}};
            w_ovf = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_m_valid    <= 1'b0;
            r_m_user     <= '0;
            r_m_fixed    <= '0;
            r_m_overflow <= 1'b0;
        end else if (w_en) begin
            r_m_valid    <= r_s1_valid;
            r_m_user     <= r_s1_user;
            r_m_fixed    <= w_res;
            r_m_overflow <= w_ovf;
        end
    end

    assign m_valid    = r_m_valid;
    assign m_user     = r_m_user;
    assign m_fixed    = r_m_fixed;
    assign m_overflow = r_m_overflow;

endmodule

// File: tb/tb_jelly_fixed_reciprocal_scale.sv
// Directed bench for jelly_fixed_reciprocal_scale in Q16.16 x Q16.16 -> Q16.16 with 8-bit user.
module tb_jelly_fixed_reciprocal_scale;

    localparam int unsigned UW = 8;

    logic          clk     = 1'b0;
    logic          reset   = 1'b0;
    logic          cke     = 1'b1;
    logic [UW-1:0] s_user  = '0;
    logic [31:0]   s_num   = '0;
    logic [31:0]   s_recip = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [UW-1:0] m_user;
    logic [31:0]   m_fixed;
    logic          m_overflow;
    logic          m_valid;
    logic          m_ready = 1'b1;

    jelly_fixed_reciprocal_scale #(
        .USER_WIDTH       (UW),
        .NUM_INT_WIDTH    (16),
        .NUM_FRAC_WIDTH   (16),
        .RECIP_INT_WIDTH  (16),
        .RECIP_FRAC_WIDTH (16),
        .M_INT_WIDTH      (16),
        .M_FRAC_WIDTH     (16)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .cke        (cke),
        .s_user     (s_user),
        .s_num      (s_num),
        .s_recip    (s_recip),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .m_user     (m_user),
        .m_fixed    (m_fixed),
        .m_overflow (m_overflow),
        .m_valid    (m_valid),
        .m_ready    (m_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] num;
        logic [31:0] recip;
        logic [31:0] fixed;
        logic        ovf;
    } vec_t;

    localparam int NV = 14;
    vec_t tbl[NV];

    int total = 0;
    int bad   = 0;

    logic [40:0] out_log[$];
    logic [40:0] log_ref[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference arithmetic in 64-bit integers: (p + 0.5 LSB) >>> 16, then clamp.
    function automatic logic [32:0] model(input logic [31:0] num, input logic [31:0] recip);
        longint p;
        p = longint'($signed(num)) * longint'($signed(recip));
        p = (p + 64'sd32768) >>> 16;
        if (p > 64'sd2147483647) return {1'b1, 32'h7FFFFFFF};
        if (p < -64'sd2147483648) return {1'b1, 32'h80000000};
        return {1'b0, p[31:0]};
    endfunction

    task automatic one_item(input string name, input logic [31:0] num, input logic [31:0] recip,
                            input logic [UW-1:0] user, input logic [31:0] exp_fixed,
                            input logic exp_ovf);
        int lat;
        s_num   = num;
        s_recip = recip;
        s_user  = user;
        s_valid = 1'b1;
        m_ready = 1'b1;
        lat     = 0;
        do begin
            @(posedge clk); #1;
            s_valid = 1'b0;
            lat++;
        end while (!m_valid && lat < 10);
        check({name, " latency"}, 64'(lat), 64'd3);
        check({name, " fixed"}, 64'(m_fixed), 64'(exp_fixed));
        check({name, " ovf"}, 64'(m_overflow), 64'(exp_ovf));
        check({name, " user"}, 64'(m_user), 64'(user));
        @(posedge clk); #1;
    endtask

    task automatic run_stream(input string name, input int n, input bit stall_mode,
                              input bit cke_drop);
        logic [32:0]   expq[$];
        logic [UW-1:0] userq[$];
        logic [32:0]   e;
        logic [UW-1:0] u;
        int            sent;
        int            got;
        int            cyc;
        logic          prev_hold;
        logic          prev_cke;
        logic          prev_mv;
        logic [31:0]   h_fixed;
        logic [UW-1:0] h_user;
        logic          h_ovf;
        logic          in_x;
        logic          out_x;
        sent = 0; got = 0; cyc = 0;
        prev_hold = 1'b0; prev_cke = 1'b1; prev_mv = 1'b0;
        h_fixed = '0; h_user = '0; h_ovf = 1'b0;
        out_log.delete();
        while (got < n && cyc < 300) begin
            if (prev_hold) begin
                check({name, " hold valid"}, 64'(m_valid), 64'd1);
                check({name, " hold fixed"}, 64'(m_fixed), 64'(h_fixed));
                check({name, " hold user"}, 64'(m_user), 64'(h_user));
                check({name, " hold ovf"}, 64'(m_overflow), 64'(h_ovf));
            end
            if (!prev_cke) check({name, " cke valid"}, 64'(m_valid), 64'(prev_mv));
            cke     = !(cke_drop && cyc >= 3 && cyc < 7);
            m_ready = stall_mode ? (cyc >= 5 && $urandom_range(0, 1) == 1) : 1'b1;
            s_valid = (sent < n);
            s_num   = tbl[sent % NV].num;
            s_recip = tbl[sent % NV].recip;
            s_user  = 8'hA0 + 8'(sent);
            #1;
            if (m_valid && !m_ready) check({name, " s_ready stalled"}, 64'(s_ready), 64'd0);
            in_x  = s_valid && s_ready && cke;
            out_x = m_valid && m_ready && cke;
            if (out_x) begin
                if (expq.size() == 0) begin
                    check({name, " extra item"}, 64'd1, 64'd0);
                end else begin
                    e = expq.pop_front();
                    u = userq.pop_front();
                    check({name, " fixed"}, 64'(m_fixed), 64'(e[31:0]));
                    check({name, " ovf"}, 64'(m_overflow), 64'(e[32]));
                    check({name, " user"}, 64'(m_user), 64'(u));
                end
                out_log.push_back({m_user, m_overflow, m_fixed});
                got++;
            end
            if (in_x) begin
                expq.push_back(model(s_num, s_recip));
                userq.push_back(s_user);
                sent++;
            end
            prev_hold = m_valid && !out_x;
            prev_cke  = cke;
            prev_mv   = m_valid;
            h_fixed   = m_fixed;
            h_user    = m_user;
            h_ovf     = m_overflow;
            @(posedge clk); #1;
            s_valid = 1'b0;
            cyc++;
        end
        check({name, " count"}, 64'(got), 64'(n));
        cke     = 1'b1;
        m_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        tbl[0]  = '{"basic",    32'h00030000, 32'h00008000, 32'h00018000, 1'b0};
        tbl[1]  = '{"neg",      32'hFFFE0000, 32'h00004000, 32'hFFFF8000, 1'b0};
        tbl[2]  = '{"half_up",  32'h00000001, 32'h00008000, 32'h00000001, 1'b0};
        tbl[3]  = '{"neg_half", 32'hFFFFFFFF, 32'h00008000, 32'h00000000, 1'b0};
        tbl[4]  = '{"sat_pos",  32'h7FFF0000, 32'h00020000, 32'h7FFFFFFF, 1'b1};
        tbl[5]  = '{"sat_neg",  32'h80000000, 32'h00020000, 32'h80000000, 1'b1};
        tbl[6]  = '{"one",      32'h00010000, 32'h00010000, 32'h00010000, 1'b0};
        tbl[7]  = '{"negneg",   32'hFFFF0000, 32'hFFFF0000, 32'h00010000, 1'b0};
        tbl[8]  = '{"mixed",    32'h00028000, 32'hFFFF8000, 32'hFFFEC000, 1'b0};
        tbl[9]  = '{"p1p5",     32'h00000003, 32'h00008000, 32'h00000002, 1'b0};
        tbl[10] = '{"m1p5",     32'hFFFFFFFD, 32'h00008000, 32'hFFFFFFFF, 1'b0};
        tbl[11] = '{"max_ok",   32'h7FFFFFFF, 32'h00010000, 32'h7FFFFFFF, 1'b0};
        tbl[12] = '{"min_ok",   32'h80000000, 32'h00010000, 32'h80000000, 1'b0};
        tbl[13] = '{"minmin",   32'h80000000, 32'h80000000, 32'h7FFFFFFF, 1'b1};

        #2;
        check("reset m_valid", 64'(m_valid), 64'd0);
        check("reset m_fixed", 64'(m_fixed), 64'd0);
        check("reset m_user", 64'(m_user), 64'd0);
        check("reset m_overflow", 64'(m_overflow), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        check("post-reset s_ready", 64'(s_ready), 64'd1);
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            one_item(tbl[i].name, tbl[i].num, tbl[i].recip, 8'(i + 1), tbl[i].fixed, tbl[i].ovf);
        end

        run_stream("backpressure", 6, 1'b1, 1'b0);

        run_stream("nodrop", 8, 1'b0, 1'b0);
        log_ref = out_log;
        run_stream("ckedrop", 8, 1'b0, 1'b1);
        check("cke log size", 64'(out_log.size()), 64'(log_ref.size()));
        for (int i = 0; i < log_ref.size() && i < out_log.size(); i++) begin
            check("cke log item", 64'(out_log[i]), 64'(log_ref[i]));
        end

        // Reset with three items in flight.
        m_ready = 1'b1;
        s_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s_num   = tbl[k].num;
            s_recip = tbl[k].recip;
            s_user  = 8'h50 + 8'(k);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        check("inflight m_valid", 64'(m_valid), 64'd1);
        reset = 1'b0;
        #1;
        check("async rst m_valid", 64'(m_valid), 64'd0);
        check("async rst m_fixed", 64'(m_fixed), 64'd0);
        check("async rst m_user", 64'(m_user), 64'd0);
        check("async rst m_ovf", 64'(m_overflow), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst hold m_valid", 64'(m_valid), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("release s_ready", 64'(s_ready), 64'd1);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (m_valid) seen++;
            @(posedge clk); #1;
        end
        check("flushed items", 64'(seen), 64'd0);
        one_item("after_reset", tbl[8].num, tbl[8].recip, 8'h77, tbl[8].fixed, tbl[8].ovf);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jelly_fixed_reciprocal_scale.md
JELLY_FIXED_RECIPROCAL_SCALE -- requirements
Module: jelly_fixed_reciprocal_scale

Interface
REQ-001 Block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameters SHALL be, one per line as name, default, meaning:
- USER_WIDTH, 0, sideband width; 0 means the user ports are 1 bit wide and unused.
- NUM_INT_WIDTH, 16, numerator integer bits (signed).
- NUM_FRAC_WIDTH, 16, numerator fraction bits.
- RECIP_INT_WIDTH, 16, reciprocal integer bits (signed; fed by the fixed reciprocal stage).
- RECIP_FRAC_WIDTH, 16, reciprocal fraction bits.
- M_INT_WIDTH, 16, result integer bits (signed).
- M_FRAC_WIDTH, 16, result fraction bits.
REQ-003 Ports SHALL be, as name, direction, width, meaning:
- clk, in, 1, clock.
- reset, in, 1, asynchronous active-low reset.
- cke, in, 1, clock enable.
- s_user, in, USER_BITS, sideband.
- s_num, in, NUM_W, signed numerator.
- s_recip, in, RECIP_W, signed reciprocal.
- s_valid, in, 1, input valid.
- s_ready, out, 1, input ready.
- m_user, out, USER_BITS, sideband.
- m_fixed, out, M_W, signed quotient.
- m_overflow, out, 1, saturation occurred.
- m_valid, out, 1, output valid.
- m_ready, in, 1, output ready.
REQ-004 Derived widths SHALL be: NUM_W = NUM_INT+NUM_FRAC; RECIP_W = RECIP_INT+RECIP_FRAC; M_W = M_INT+M_FRAC; SHIFT = NUM_FRAC+RECIP_FRAC-M_FRAC. SHIFT SHALL be ≥0; elaboration SHALL fail otherwise.

Function
REQ-005 Input transfer SHALL occur iff s_valid && s_ready && cke; output transfer SHALL occur iff m_valid && m_ready && cke.
REQ-006 Pipeline SHALL have 3 register stages: S0 captures the operands, S1 holds the full product, S2 holds the rounded and saturated result. m_* SHALL be driven by S2.
REQ-007 Pipeline enable SHALL be en = cke && (!m_valid || m_ready); all stages SHALL advance together when en is high.
REQ-008 s_ready SHALL equal (!m_valid || m_ready). s_ready SHALL NOT depend on s_valid.
REQ-009 Latency SHALL be 3 enabled cycles from input transfer to m_valid of that item. Bubbles are not collapsed.
REQ-010 While cke=0, all registers SHALL hold their values, including m_valid.
REQ-011 While m_valid && !m_ready, m_fixed, m_user and m_overflow SHALL stay stable.
REQ-012 S1 SHALL hold the full signed product, NUM_W+RECIP_W bits wide, with no truncation.
REQ-013 Rounding: if SHIFT>0, add 2^(SHIFT-1) to the product, then arithmetic-shift right by SHIFT (round half toward +inf). If SHIFT=0, no rounding.
REQ-014 Saturation: if the rounded value is greater than 2^(M_W-1)-1, m_fixed SHALL be 2^(M_W-1)-1; if it is less than -2^(M_W-1), m_fixed SHALL be -2^(M_W-1). In both cases m_overflow=1; otherwise m_overflow=0.
REQ-015 s_user SHALL travel with its operands unchanged, with the same latency.
REQ-016 Item order SHALL be preserved. No item SHALL be dropped or duplicated under any m_ready pattern.
REQ-017 Simultaneous input and output transfer in one cycle SHALL be legal and SHALL lose nothing.

Reset
REQ-018 While reset=0, all stage valid flags, m_valid, m_fixed, m_user and m_overflow SHALL be 0, asynchronously.
REQ-019 Items in flight when reset asserts SHALL be discarded and SHALL never appear at the output.
REQ-020 After reset release, s_ready SHALL be 1 on the first edge.

Verification (Q16.16 in, Q16.16 reciprocal, Q16.16 out)
REQ-021 Basic: s_num=0x00030000, s_recip=0x00008000, m_ready=1 -> m_fixed=0x00018000, m_overflow=0, 3 cycles after accept.
REQ-022 Sign and rounding:
- 0xFFFE0000 x 0x00004000 -> 0xFFFF8000.
- 0x00000001 x 0x00008000 -> 0x00000001.
- 0xFFFFFFFF x 0x00008000 -> 0x00000000.
REQ-023 Saturation:
- 0x7FFF0000 x 0x00020000 -> 0x7FFFFFFF with m_overflow=1.
- 0x80000000 x 0x00020000 -> 0x80000000 with m_overflow=1.
REQ-024 Backpressure: stream 6 items with distinct s_user, m_ready=0 for 5 cycles then random -> all 6 out in order, correct values, outputs stable while stalled, s_ready=0 while full and stalled.
REQ-025 cke: drop cke for 4 cycles mid-stream -> no state change; resume -> results identical to the run without the cke drop.
REQ-026 Reset mid-operation: 3 items in flight, pulse reset low for 2 cycles -> m_valid=0 immediately, none of the 3 items emitted; a new item after release is emitted after 3 cycles.
